coin_acceptor: RTL
==================

// Module: coin_acceptor
// PURPOSE
// Front-end stage that feeds the pencil vending FSM. Synchronises and debounces the raw
// coin sensor level, then measures how long each coin blocks the sensor to classify it as
// 5 or 10 cents. Queues accepted coins in a small FIFO and issues each one as a single-cycle
// coin_in_en/coin_val pulse. Invalid or unqueueable coins get a coin_reject pulse.
// PARAMETERS
// DEBOUNCE_CYC  4   consecutive stable synced samples needed to change the filtered level
// NICKEL_MIN    8   min filtered-high width (cycles) classified as 5 cents
// NICKEL_MAX    15  max width classified as 5 cents
// DIME_MIN      20  min width classified as 10 cents
// DIME_MAX      31  max width classified as 10 cents
// FIFO_DEPTH    4   queued coin slots (power of 2)
// GAP_CYC       2   minimum idle cycles between consecutive coin_in_en pulses
// CNT_W         6   width-counter bits; saturates at 2^CNT_W-1
// PORTS
// clk          in   1  single clock, rising edge
// reset        in   1  synchronous, active-low; clears all state
// coin_sense   in   1  raw asynchronous sensor level, 1 = coin blocking sensor
// hold         in   1  1 = downstream busy; keep coins queued, issue nothing
// coin_in_en   out  1  one-cycle pulse: a coin is delivered downstream
// coin_val     out  1  valid with coin_in_en: 0 = 5 cents, 1 = 10 cents; else 0
// coin_reject  out  1  one-cycle pulse: coin rejected (bad width or FIFO full)
// fifo_full    out  1  FIFO holds FIFO_DEPTH coins
// pending      out  3  number of queued coins, 0..FIFO_DEPTH
// BEHAVIOUR
// - Reset (reset==0 at clk edge): all outputs 0. FIFO is emptied, queued coins are lost.
//   The synchroniser, filtered level and debounce counter are cleared to 0.
//   The measurement FSM goes to IDLE and the gap counter goes to 0.
// - Synchroniser: 2 flops. Debounce: filtered level flips only after the synced value
//   differs from it for DEBOUNCE_CYC consecutive cycles. Shorter glitches are ignored.
// - Measure FSM: IDLE -> MEASURE on filtered rise, with width=1.
//   MEASURE: width+1 per filtered-high cycle, saturating. Filtered fall -> CLASSIFY.
//   CLASSIFY (1 cycle) -> IDLE:
//   width in [NICKEL_MIN,NICKEL_MAX] -> push 0;
//   width in [DIME_MIN,DIME_MAX] -> push 1;
//   any other width, including saturated -> coin_reject=1 next cycle, no push.
//   A valid push while the FIFO is full and no pop occurs this cycle -> coin_reject, coin dropped.
//   Push and pop in the same cycle is legal when full; count is unchanged.
// - Issue: when pending>0, hold==0 and gap counter==0, the head is popped.
//   The next cycle then shows coin_in_en=1 and coin_val=head.
//   The gap counter loads GAP_CYC and decrements to 0, blocking further issue.
//   hold is sampled each cycle; it never truncates a pulse already registered.
// - Latency, clean pulse with hold=0 and empty FIFO: raw fall -> coin_in_en is
//   2 (sync) + DEBOUNCE_CYC + 1 (CLASSIFY) + 1 (pop) + 1 (output reg) cycles.
// - FIFO pointers wrap modulo FIFO_DEPTH. pending equals write count minus read count.
//   fifo_full = (pending==FIFO_DEPTH).
// - All outputs are registered. coin_in_en and coin_reject are never high longer than 1 cycle.
//   Both may be high in the same cycle.
// TESTING
// - Clean 12-cycle high on coin_sense, hold=0 -> exactly one coin_in_en with coin_val=0,
//   at the stated latency; no coin_reject.
// - Clean 25-cycle pulse -> one coin_in_en with coin_val=1. Then 17-cycle and 40-cycle
//   pulses -> one coin_reject each, no coin_in_en.
// - 2-cycle glitch -> no output activity. 12-cycle pulse with single-cycle dropouts inside
//   -> a single 5-cent coin.
// - hold=1, insert 5 dimes -> pending steps to 4, fifo_full=1, 5th gives coin_reject.
//   Release hold -> 4 pulses with coin_val=1, each separated by >=GAP_CYC idle cycles;
//   pending returns to 0.
// - FIFO full and hold=0: coin classifies valid in the same cycle as a pop -> accepted, no reject.
// - reset=0 for 1 cycle mid-MEASURE with 2 coins queued -> all outputs 0 next edge.
//   No stale coin_in_en afterwards; a sensor still high at release is then measured as a new coin.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor and hold in, coin delivery/reject/status out.
// The master side stimulates the sensor; the slave side is the acceptor itself.
interface coin_acceptor_if;
  logic       coin_sense;
  logic       hold;
  logic       coin_in_en;
  logic       coin_val;
  logic       coin_reject;
  logic       fifo_full;
  logic [2:0] pending;

  modport master (
    output coin_sense, hold,
    input  coin_in_en, coin_val, coin_reject, fifo_full, pending
  );

  modport slave (
    input  coin_sense, hold,
    output coin_in_en, coin_val, coin_reject, fifo_full, pending
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: sync + debounce the sensor, classify each coin by blocking
// width, queue accepted coins and issue them as rate-limited single-cycle pulses.
module coin_acceptor #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int NICKEL_MIN   = 8,
  parameter int NICKEL_MAX   = 15,
  parameter int DIME_MIN     = 20,
  parameter int DIME_MAX     = 31,
  parameter int FIFO_DEPTH   = 4,
  parameter int GAP_CYC      = 2,
  parameter int CNT_W        = 6
) (
  input logic           clk,
  input logic           reset,
  coin_acceptor_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_F = PTR_W + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC) + 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_CLASSIFY
  } state_t;

  logic             r_sync1, r_sync2, r_filt;
  logic [DB_W-1:0]  r_db_cnt;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_width, w_width_nxt;
  logic             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_F-1:0] r_count, w_count_nxt;
  logic             r_full;
  logic [GAP_W-1:0] r_gap;
  logic             r_in_en, r_val, r_reject;

  logic w_push_req, w_push_val, w_bad_width;
  logic w_pop, w_push_ok, w_drop;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_filt   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= bus.coin_sense;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_filt) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          r_filt   <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_width <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_width <= w_width_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_width_nxt = r_width;
    w_push_req  = 1'b0;
    w_push_val  = 1'b0;
    w_bad_width = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_filt) begin
          w_state_nxt = S_MEASURE;
          w_width_nxt = CNT_W'(1);
        end
      end
      S_MEASURE: begin
        if (!r_filt) begin
          w_state_nxt = S_CLASSIFY;
        end else if (r_width != {CNT_W{1'b1}}) begin
          w_width_nxt = r_width + CNT_W'(1);
        end
      end
      S_CLASSIFY: begin
        w_state_nxt = S_IDLE;
        if (r_width >= CNT_W'(NICKEL_MIN) && r_width <= CNT_W'(NICKEL_MAX)) begin
          w_push_req = 1'b1;
        end else if (r_width >= CNT_W'(DIME_MIN) && r_width <= CNT_W'(DIME_MAX)) begin
          w_push_req = 1'b1;
          w_push_val = 1'b1;
        end else begin
          w_bad_width = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a coin when the head leaves in the same cycle.
  always_comb begin
    w_pop       = (r_count != '0) && !bus.hold && (r_gap == '0);
    w_push_ok   = w_push_req && (!r_full || w_pop);
    w_drop      = w_push_req && !w_push_ok;
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + CNT_F'(1);
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - CNT_F'(1);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_push_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_gap    <= '0;
      r_in_en  <= 1'b0;
      r_val    <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_F'(FIFO_DEPTH));
      if (w_pop) begin
        r_gap <= GAP_W'(GAP_CYC);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GAP_W'(1);
      end
      r_in_en  <= w_pop;
      r_val    <= w_pop && r_mem[r_rd_ptr];
      r_reject <= w_bad_width || w_drop;
    end
  end

  assign bus.coin_in_en  = r_in_en;
  assign bus.coin_val    = r_val;
  assign bus.coin_reject = r_reject;
  assign bus.fifo_full   = r_full;
  assign bus.pending     = r_count;

endmodule
